// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory stage: opcode/funct3 decode constants,
// FSM state encoding and small helpers for access size, alignment and store
// lane placement.
package memory_access_pkg;

    localparam logic [4:0] OP5_LOAD  = 5'b00000;
    localparam logic [4:0] OP5_STORE = 5'b01000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // f3[1:0] alone gives the access size: 00 byte, 01 half, anything else
    // (including the unsupported encodings) is handled as a word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   store_strb = 4'b0001 << a;
            2'b01:   store_strb = 4'b0011 << a;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   store_wdata = {4{rs2[7:0]}};
            2'b01:   store_wdata = {2{rs2[15:0]}};
            default: store_wdata = rs2;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Load lane alignment and extension (combinational).
// Ports:
//   rdata  in  32  raw word from data memory
//   lane   in  2   byte offset of the access within the word
//   f3     in  3   load funct3 (LB/LH/LW/LBU/LHU; others behave as LW)
//   data   out 32  aligned, sign/zero-extended load result
module mem_load_align
    import memory_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  f3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        data = rdata;
        case (f3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory pipeline stage feeding writeback. Loads/stores go through a
// req/ready data-memory port with a timeout; other instructions pass the
// execute result through with one cycle of latency.
// Ports:
//   clk, rst (async, active-high)
//   valid_in, instr, execute_out, rs2_data   upstream instruction (held while busy)
//   busy                                     stage occupied (core stall)
//   valid_out, instr_out, memory_out         one-cycle result pulse to writeback
//   misalign, bus_error                      qualifiers of valid_out
//   dmem_req/we/addr/wstrb/wdata             data-memory request
//   dmem_ready, dmem_rdata                   data-memory response
module memory_access
    import memory_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] instr,
    input  logic [31:0] execute_out,
    input  logic [31:0] rs2_data,
    output logic        busy,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] memory_out,
    output logic        misalign,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t           state, state_next;
    logic [CNT_W-1:0] count;
    logic [2:0]       f3_q;
    logic [1:0]       lane_q;
    logic [31:0]      load_data;

    logic [4:0] op5;
    logic [2:0] f3;
    logic       is_load, is_store, is_mem, bad_align, timed_out;

    assign op5       = instr[6:2];
    assign f3        = instr[14:12];
    assign is_load   = (op5 == OP5_LOAD);
    assign is_store  = (op5 == OP5_STORE);
    assign is_mem    = is_load | is_store;
    assign bad_align = is_misaligned(f3, execute_out[1:0]);
    assign timed_out = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Decoded straight from state so that an async reset clears them at once.
    assign busy      = (state != IDLE);
    assign valid_out = (state == RESP);
    assign dmem_req  = (state == ACCESS);

    mem_load_align u_load_align (
        .rdata (dmem_rdata),
        .lane  (lane_q),
        .f3    (f3_q),
        .data  (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (valid_in) state_next = (is_mem && !bad_align) ? ACCESS : RESP;
            end
            // Ready is checked first, so a response on the timeout cycle wins.
            ACCESS: begin
                if (dmem_ready || timed_out) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---- accept / access / response datapath ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            f3_q       <= '0;
            lane_q     <= '0;
            instr_out  <= '0;
            memory_out <= '0;
            misalign   <= 1'b0;
            bus_error  <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wstrb <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        instr_out  <= instr;
                        memory_out <= execute_out;
                        misalign   <= is_mem && bad_align;
                        bus_error  <= 1'b0;
                        count      <= '0;
                        f3_q       <= f3;
                        lane_q     <= execute_out[1:0];
                        if (is_mem && !bad_align) begin
                            dmem_addr  <= {execute_out[31:2], 2'b00};
                            dmem_we    <= is_store;
                            dmem_wstrb <= is_store ? store_strb(f3, execute_out[1:0]) : 4'b0000;
                            dmem_wdata <= is_store ? store_wdata(f3, rs2_data) : 32'd0;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ready) begin
                        if (!dmem_we) memory_out <= load_data;
                    end else if (timed_out) begin
                        bus_error  <= 1'b1;
                        memory_out <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] execute_out = '0;
    logic [31:0] rs2_data = '0;
    logic        busy, valid_out, misalign, bus_error;
    logic [31:0] instr_out, memory_out;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] data;
        logic        mis;
        logic        berr;
        int          busy;
    } exp_t;

    exp_t sb[$];

    memory_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .instr       (instr),
        .execute_out (execute_out),
        .rs2_data    (rs2_data),
        .busy        (busy),
        .valid_out   (valid_out),
        .instr_out   (instr_out),
        .memory_out  (memory_out),
        .misalign    (misalign),
        .bus_error   (bus_error),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // Monitor: counts busy cycles per transaction and checks every valid_out
    // against the head of the scoreboard.
    initial begin
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (valid_out) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid: got valid_out=1 memory_out=%h want no response", memory_out);
                    end else begin
                        e = sb.pop_front();
                        if ({instr_out, memory_out, misalign, bus_error} !== {e.instr, e.data, e.mis, e.berr}) begin
                            errors++;
                            $display("FAIL resp instr %h: got out=%h mis=%b berr=%b instr=%h want out=%h mis=%b berr=%b",
                                     e.instr, memory_out, misalign, bus_error, instr_out, e.data, e.mis, e.berr);
                        end
                        checks++;
                        if (busy_cnt != e.busy) begin
                            errors++;
                            $display("FAIL busy_len instr %h: got %0d want %0d", e.instr, busy_cnt, e.busy);
                        end
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] i, input logic [31:0] eo, input logic [31:0] rs2,
                         input logic [31:0] exp_data, input logic exp_mis, input logic exp_berr,
                         input int exp_busy, input logic exp_req, input logic [31:0] exp_addr,
                         input logic exp_we, input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                         input int ready_wait, input logic [31:0] rdata);
        exp_t e;
        int   n;
        logic seen;
        e.instr = i; e.data = exp_data; e.mis = exp_mis; e.berr = exp_berr; e.busy = exp_busy;
        sb.push_back(e);
        @(negedge clk);
        valid_in = 1'b1; instr = i; execute_out = eo; rs2_data = rs2;
        @(posedge clk);
        #1 valid_in = 1'b0;
        if (exp_req) begin
            n = 0; seen = 1'b0;
            while (!seen && n < 10) begin
                @(negedge clk);
                n++;
                if (dmem_req) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL req_wait instr %h: got dmem_req=0 want 1", i);
            end else if ({dmem_addr, dmem_we, dmem_wstrb, dmem_wdata} !== {exp_addr, exp_we, exp_strb, exp_wdata}) begin
                errors++;
                $display("FAIL bus instr %h: got addr=%h we=%b strb=%b wdata=%h want addr=%h we=%b strb=%b wdata=%h",
                         i, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata, exp_addr, exp_we, exp_strb, exp_wdata);
            end
            if (seen && ready_wait >= 0) begin
                repeat (ready_wait) @(negedge clk);
                dmem_ready = 1'b1; dmem_rdata = rdata;
                @(posedge clk);
                #1 dmem_ready = 1'b0; dmem_rdata = '0;
            end
        end
        n = 0; seen = 1'b0;
        do begin
            @(negedge clk);
            if (dmem_req) seen = 1'b1;
            n++;
        end while (busy && n < 50);
        if (!exp_req) begin
            checks++;
            if (seen) begin
                errors++;
                $display("FAIL no_req instr %h: got dmem_req=1 want 0", i);
            end
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL idle_wait instr %h: got busy=1 want 0", i);
        end
    endtask

    initial begin
        int n;
        #3;
        checks++;
        if ({busy, valid_out, dmem_req, dmem_we, dmem_wstrb, misalign, bus_error, memory_out, instr_out, dmem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b vo=%b req=%b mo=%h want all 0", busy, valid_out, dmem_req, memory_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ADD passes execute_out through
        issue(32'h0000_0033, 32'h0000_1234, 32'h0, 32'h0000_1234, 0, 0, 1, 0, 0, 0, 4'b0, 0, -1, 0);

        // Reset while a load is waiting on the bus
        @(negedge clk);
        valid_in = 1'b1; instr = 32'h0000_2003; execute_out = 32'h0000_0600;
        @(posedge clk);
        #1 valid_in = 1'b0;
        n = 0;
        while (!dmem_req && n < 10) begin @(negedge clk); n++; end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({dmem_req, busy, valid_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_access: got req=%b busy=%b vo=%b want 000", dmem_req, busy, valid_out);
        end
        @(negedge clk);
        rst = 1'b0;

        // LB 0x103, ready on the 4th access cycle
        issue(32'h0000_0003, 32'h0000_0103, 32'h0, 32'hFFFF_FF80, 0, 0, 5, 1, 32'h100, 0, 4'b0000, 32'h0, 3, 32'h80FF_FFFF);
        // SH 0x202
        issue(32'h0000_1023, 32'h0000_0202, 32'hABCD_1234, 32'h0000_0202, 0, 0, 2, 1, 32'h200, 1, 4'b1100, 32'h1234_1234, 0, 0);
        // LW misaligned 0x301
        issue(32'h0000_2003, 32'h0000_0301, 32'h0, 32'h0000_0301, 1, 0, 1, 0, 0, 0, 4'b0, 0, -1, 0);
        // LHU 0x302
        issue(32'h0000_5003, 32'h0000_0302, 32'h0, 32'h0000_9ABC, 0, 0, 3, 1, 32'h300, 0, 4'b0000, 32'h0, 1, 32'h9ABC_0000);
        // LW timeout (TIMEOUT_CYCLES=4)
        issue(32'h0000_2003, 32'h0000_0400, 32'h0, 32'h0000_0000, 0, 1, 5, 1, 32'h400, 0, 4'b0000, 32'h0, -1, 0);
        // LW with ready on the timeout cycle: ready wins
        issue(32'h0000_2003, 32'h0000_0404, 32'h0, 32'hDEAD_BEEF, 0, 0, 5, 1, 32'h404, 0, 4'b0000, 32'h0, 3, 32'hDEAD_BEEF);
        // LH 0x102 sign-extends upper half
        issue(32'h0000_1003, 32'h0000_0102, 32'h0, 32'hFFFF_8001, 0, 0, 2, 1, 32'h100, 0, 4'b0000, 32'h0, 0, 32'h8001_0000);
        // LBU 0x101 zero-extends
        issue(32'h0000_4003, 32'h0000_0101, 32'h0, 32'h0000_00F1, 0, 0, 2, 1, 32'h100, 0, 4'b0000, 32'h0, 0, 32'h0000_F100);
        // SB 0x203
        issue(32'h0000_0023, 32'h0000_0203, 32'h0000_00A5, 32'h0000_0203, 0, 0, 2, 1, 32'h200, 1, 4'b1000, 32'hA5A5_A5A5, 0, 0);
        // SW 0x208
        issue(32'h0000_2023, 32'h0000_0208, 32'h1357_9BDF, 32'h0000_0208, 0, 0, 2, 1, 32'h208, 1, 4'b1111, 32'h1357_9BDF, 0, 0);
        // SH misaligned 0x201
        issue(32'h0000_1023, 32'h0000_0201, 32'hFFFF_FFFF, 32'h0000_0201, 1, 0, 1, 0, 0, 0, 4'b0, 0, -1, 0);
        // Unsupported f3=011 load behaves as LW
        issue(32'h0000_3003, 32'h0000_0500, 32'h0, 32'h1122_3344, 0, 0, 2, 1, 32'h500, 0, 4'b0000, 32'h0, 0, 32'h1122_3344);
        // Store timeout returns memory_out=0
        issue(32'h0000_2023, 32'h0000_0600, 32'h0BAD_F00D, 32'h0000_0000, 0, 1, 5, 1, 32'h600, 1, 4'b1111, 32'h0BAD_F00D, -1, 0);

        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending responses want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
